frogger_status_controller: RTL

//   Game-status FSM fed by the last-register comparator's 2-bit win code
//   (11 = frog reached last row, 01 = collision, 00 = nothing). Tracks lives
//   and level, freezes the board (pause) during hit/level-up holds, and pulses

---
 rtl/frogger_status_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/frogger_status_controller.sv
// Game-status controller for the frogger board.
// Consumes the last-register comparator's 2-bit win code and tracks lives and
// level. It freezes the board during hit and level-up holds, and pulses a
// one-cycle reload to the lane registers. The current state code is exported
// for the display/score blocks and doubles as the FSM debug view.
// There is no valid/ready handshake on this block: the win code is a level
// that is sampled every cycle while in PLAY. The tick input is a one-cycle
// pulse that is only counted during holds.
module frogger_status_controller #(
    parameter int LIVES_INIT  = 3,
    parameter int LIVES_WIDTH = 2,
    parameter int LEVEL_MAX   = 4,
    parameter int LEVEL_WIDTH = 3,
    parameter int HOLD_TICKS  = 8
) (
    input  logic                   STATUS_CLOCK_50,
    input  logic                   STATUS_RESET_InHigh,
    input  logic                   STATUS_start_InLow,
    input  logic                   STATUS_tick_In,
    input  logic [1:0]             STATUS_win_InBUS,
    output logic                   STATUS_clear_Out,
    output logic                   STATUS_pause_Out,
    output logic [LIVES_WIDTH-1:0] STATUS_lives_OutBUS,
    output logic [LEVEL_WIDTH-1:0] STATUS_level_OutBUS,
    output logic [2:0]             STATUS_state_OutBUS
);

    localparam int HOLD_WIDTH = $clog2(HOLD_TICKS + 1);

    localparam logic [LIVES_WIDTH-1:0] livesInit = LIVES_WIDTH'(LIVES_INIT);
    localparam logic [LIVES_WIDTH-1:0] livesOne  = LIVES_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0] levelLast = LEVEL_WIDTH'(LEVEL_MAX - 1);
    localparam logic [HOLD_WIDTH-1:0]  holdLast  = HOLD_WIDTH'(HOLD_TICKS);

    localparam logic [1:0] winReached   = 2'b11;
    localparam logic [1:0] winCollision = 2'b01;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        PLAY     = 3'd2,
        HIT      = 3'd3,
        LEVELUP  = 3'd4,
        GAMEOVER = 3'd5,
        VICTORY  = 3'd6,
        UNUSED   = 3'd7
    } stateType;

    stateType               state;
    stateType               stateNext;
    logic [LIVES_WIDTH-1:0] lives;
    logic [LIVES_WIDTH-1:0] livesNext;
    logic [LEVEL_WIDTH-1:0] level;
    logic [LEVEL_WIDTH-1:0] levelNext;
    logic [HOLD_WIDTH-1:0]  hold;
    logic [HOLD_WIDTH-1:0]  holdNext;
    logic [HOLD_WIDTH-1:0]  holdInc;
    logic                   clearReg;
    logic                   clearNext;
    logic                   pauseReg;
    logic                   pauseNext;

    assign holdInc = hold + HOLD_WIDTH'(1);

    // State, counters and registered outputs; reset wins from any state.
    always_ff @(posedge STATUS_CLOCK_50) begin
        if (STATUS_RESET_InHigh) begin
            state    <= IDLE;
            lives    <= livesInit;
            level    <= '0;
            hold     <= '0;
            clearReg <= 1'b0;
            pauseReg <= 1'b1;
        end else begin
            state    <= stateNext;
            lives    <= livesNext;
            level    <= levelNext;
            hold     <= holdNext;
            clearReg <= clearNext;
            pauseReg <= pauseNext;
        end
    end

    // Next-state and counter updates; the win code only matters in PLAY.
    always_comb begin
        stateNext = state;
        livesNext = lives;
        levelNext = level;
        holdNext  = '0;
        case (state)
            IDLE, GAMEOVER, VICTORY: begin
                if (!STATUS_start_InLow) begin
                    stateNext = LOAD;
                    livesNext = livesInit;
                    levelNext = '0;
                end
            end
            LOAD: begin
                stateNext = PLAY;
            end
            PLAY: begin
                if (STATUS_win_InBUS == winReached) begin
                    if (level >= levelLast) begin
                        stateNext = VICTORY;
                    end else begin
                        levelNext = level + LEVEL_WIDTH'(1);
                        stateNext = LEVELUP;
                    end
                end else if (STATUS_win_InBUS == winCollision) begin
                    // Lives saturate at zero: the last life ends the game.
                    if (lives <= livesOne) begin
                        livesNext = '0;
                        stateNext = GAMEOVER;
                    end else begin
                        livesNext = lives - livesOne;
                        stateNext = HIT;
                    end
                end
            end
            HIT, LEVELUP: begin
                // Without ticks the hold simply waits.
                holdNext = hold;
                if (STATUS_tick_In) begin
                    if (holdInc >= holdLast) begin
                        holdNext  = '0;
                        stateNext = LOAD;
                    end else begin
                        holdNext = holdInc;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the outputs come from registers.
    always_comb begin
        clearNext = (stateNext == LOAD);
        pauseNext = (stateNext != PLAY);
    end

    assign STATUS_clear_Out    = clearReg;
    assign STATUS_pause_Out    = pauseReg;
    assign STATUS_lives_OutBUS = lives;
    assign STATUS_level_OutBUS = level;
    assign STATUS_state_OutBUS = state;

endmodule
